// File: rtl/bitwise_pkg.sv
// Shared types for the bitwise serializer front end.
// State encoding and counter sizing helpers.
package bitwise_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_e;

  localparam int unsigned GAP_W = 4;
  localparam int unsigned GAP_MAX = 15;

  function automatic int unsigned cnt_w(int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/bitwise_serializer.sv
// Parallel-in, serial-out feeder for the bitwise shift register.
// Emits each accepted word MSB first on d/en, then pulses done.
module bitwise_serializer
  import bitwise_pkg::*;
#(
  parameter int unsigned p_nbits    = 8,
  parameter int unsigned p_gap      = 0,
  parameter logic        p_idle_bit = 1'b0
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [p_nbits-1:0] in_data,
  input  logic               in_valid,
  output logic               in_ready,
  output logic               d,
  output logic               en,
  output logic               busy,
  output logic               done
);

  localparam int unsigned CW = cnt_w(p_nbits);
  localparam logic [CW-1:0] CNT_LAST = CW'(p_nbits - 1);
  localparam logic [GAP_W-1:0] GAP_LOAD =
    GAP_W'((p_gap > 0) ? p_gap - 1 : 0);
  localparam logic HAS_GAP = (p_gap != 0);

  if (p_nbits < 2) begin : g_bad_nbits
    $error("bitwise_serializer: p_nbits must be >= 2");
  end
  if (p_gap > GAP_MAX) begin : g_bad_gap
    $error("bitwise_serializer: p_gap must be <= 15");
  end

  state_e             state_q;
  logic [p_nbits-1:0] shreg_q;
  logic [CW-1:0]      cnt_q;
  logic [GAP_W-1:0]   gap_q;
  logic               done_q;
  logic               last;

  assign last = (cnt_q == '0);

  // Ready only in IDLE or on the final bit of a gapless word.
  assign in_ready = (state_q == IDLE) ||
                    ((state_q == SHIFT) && last && !HAS_GAP);
  assign en   = (state_q == SHIFT);
  assign d    = en ? shreg_q[p_nbits-1] : p_idle_bit;
  assign busy = (state_q != IDLE);
  assign done = done_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      gap_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            state_q <= SHIFT;
            shreg_q <= in_data;
            cnt_q   <= CNT_LAST;
          end
        end
        SHIFT: begin
          shreg_q <= shreg_q << 1;
          cnt_q   <= cnt_q - 1'b1;
          if (last) begin
            done_q <= 1'b1;
            if (HAS_GAP) begin
              state_q <= GAP;
              gap_q   <= GAP_LOAD;
            end else if (in_valid) begin
              shreg_q <= in_data;
              cnt_q   <= CNT_LAST;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        GAP: begin
          if (gap_q == '0) begin
            state_q <= IDLE;
          end else begin
            gap_q <= gap_q - 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bitwise_serializer.sv
// Bench for bitwise_serializer: a gapless and a gapped instance
// compared cycle by cycle against an expected output trace.
module tb_bitwise_serializer;

  typedef struct packed {
    logic       en;
    logic       d;
    logic       rdy;
    logic       busy;
    logic       done;
    logic       acc;
    logic [7:0] w;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       vld [2];
  logic [7:0] dat [2];
  logic       rdy [2];
  logic       dd  [2];
  logic       ee  [2];
  logic       bb  [2];
  logic       dn  [2];

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  bitwise_serializer #(
    .p_nbits(8), .p_gap(0), .p_idle_bit(1'b0)
  ) u0 (
    .clk(clk), .reset_n(reset_n),
    .in_data(dat[0]), .in_valid(vld[0]),
    .in_ready(rdy[0]), .d(dd[0]), .en(ee[0]),
    .busy(bb[0]), .done(dn[0])
  );

  bitwise_serializer #(
    .p_nbits(8), .p_gap(3), .p_idle_bit(1'b1)
  ) u1 (
    .clk(clk), .reset_n(reset_n),
    .in_data(dat[1]), .in_valid(vld[1]),
    .in_ready(rdy[1]), .d(dd[1]), .en(ee[1]),
    .busy(bb[1]), .done(dn[1])
  );

  function automatic logic idle_of(int s);
    return (s == 1) ? 1'b1 : 1'b0;
  endfunction

  function automatic exp_t mk(logic en, logic d, logic rdy,
                              logic busy, logic done, logic acc,
                              logic [7:0] w);
    exp_t e;
    e.en = en; e.d = d; e.rdy = rdy; e.busy = busy;
    e.done = done; e.acc = acc; e.w = w;
    return e;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(int s, string tag);
    chk({tag, ".en"}, 32'(ee[s]), 32'd0);
    chk({tag, ".d"}, 32'(dd[s]), 32'(idle_of(s)));
    chk({tag, ".rdy"}, 32'(rdy[s]), 32'd1);
    chk({tag, ".busy"}, 32'(bb[s]), 32'd0);
    chk({tag, ".done"}, 32'(dn[s]), 32'd0);
  endtask

  // Expected trace from the protocol rules, starting at the first accept.
  task automatic run(int s, int gap, logic [7:0] words[$], string tag);
    exp_t tr[$];
    logic [7:0] dq[$];
    logic [7:0] q;
    logic idle;
    int nw;
    int accepted;
    idle = idle_of(s);
    nw = words.size();
    tr.push_back(mk(0, idle, 1, 0, 0, 1, words[0]));
    for (int w = 0; w < nw; w++) begin
      for (int k = 0; k < 8; k++) begin
        logic more;
        logic [7:0] nx;
        more = (k == 7) && (gap == 0) && (w < nw - 1);
        nx = more ? words[w + 1] : 8'h00;
        tr.push_back(mk(1, words[w][7 - k],
                        (k == 7) && (gap == 0), 1,
                        (k == 0) && (w > 0) && (gap == 0),
                        more, nx));
      end
      if (gap > 0) begin
        for (int g = 0; g < gap; g++)
          tr.push_back(mk(0, idle, 0, 1, g == 0, 0, 8'h00));
        if (w < nw - 1)
          tr.push_back(mk(0, idle, 1, 0, 0, 1, words[w + 1]));
        else
          tr.push_back(mk(0, idle, 1, 0, 0, 0, 8'h00));
      end else if (w == nw - 1) begin
        tr.push_back(mk(0, idle, 1, 0, 1, 0, 8'h00));
      end
    end
    tr.push_back(mk(0, idle, 1, 0, 0, 0, 8'h00));
    dq = words;
    q = 8'h00;
    accepted = 0;
    foreach (tr[i]) begin
      exp_t e;
      e = tr[i];
      vld[s] = (accepted < nw);
      dat[s] = e.acc ? e.w :
               (accepted < nw) ? words[accepted] : 8'($urandom);
      chk({tag, ".en"}, 32'(ee[s]), 32'(e.en));
      chk({tag, ".d"}, 32'(dd[s]), 32'(e.d));
      chk({tag, ".rdy"}, 32'(rdy[s]), 32'(e.rdy));
      chk({tag, ".busy"}, 32'(bb[s]), 32'(e.busy));
      chk({tag, ".done"}, 32'(dn[s]), 32'(e.done));
      if (e.done && dq.size() > 0)
        chk({tag, ".q"}, 32'(q), 32'(dq.pop_front()));
      if (e.acc) accepted++;
      if (ee[s]) q = {q[6:0], dd[s]};
      step();
      if (accepted >= nw) begin
        vld[s] = 1'b0;
        dat[s] = 8'($urandom);
      end
    end
    vld[s] = 1'b0;
  endtask

  initial begin
    logic [7:0] wq[$];
    reset_n = 1'b0;
    vld[0] = 1'b0; vld[1] = 1'b0;
    dat[0] = 8'h00; dat[1] = 8'h00;
    repeat (2) step();
    chk_idle(0, "rst0");
    chk_idle(1, "rst1");
    reset_n = 1'b1;
    step();

    wq = {8'hA5};
    run(0, 0, wq, "single");

    wq = {8'h3C, 8'hFF};
    run(0, 0, wq, "b2b");

    wq = {};
    for (int i = 0; i < 4; i++) wq.push_back(8'($urandom));
    run(0, 0, wq, "b2b_rnd");

    wq = {8'h5A, 8'hC3};
    run(1, 3, wq, "gap");

    wq = {};
    for (int i = 0; i < 3; i++) wq.push_back(8'($urandom));
    run(1, 3, wq, "gap_rnd");

    for (int i = 0; i < 5; i++) begin
      dat[0] = 8'($urandom);
      chk_idle(0, "stall");
      step();
    end

    vld[0] = 1'b1;
    dat[0] = 8'hF0;
    step();
    vld[0] = 1'b0;
    dat[0] = 8'h0F;
    for (int k = 0; k < 4; k++) begin
      chk("midrst.en", 32'(ee[0]), 32'd1);
      chk("midrst.d", 32'(dd[0]), 32'd1);
      step();
    end
    reset_n = 1'b0;
    #1;
    chk_idle(0, "midrst.async");
    step();
    chk_idle(0, "midrst.hold");
    reset_n = 1'b1;
    step();
    chk_idle(0, "midrst.after");

    wq = {8'h81};
    run(0, 0, wq, "post_rst");

    wq = {};
    for (int i = 0; i < 2; i++) wq.push_back(8'($urandom));
    run(0, 0, wq, "tail_rnd");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
